interp_sequencer: RTL and testbench

INTERP_SEQUENCER -- requirements
Module: interp_sequencer

---
 rtl/interp_sequencer.sv | 151 +++++++++++++++
 tb/tb_interp_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_sequencer.sv
// interp_sequencer: plays back a stored waveform by stepping sample-RAM read
// addresses once per interpolation segment and pulsing the interpolator at
// every segment start.
//
// Ports:
//   Fg_clk  - clock, all state updates on rising edge
//   Resetn  - asynchronous active-low reset
//   Start   - level-sampled; starts playback from sample 0 when idle
//   Stop    - level-sampled; aborts playback (wins over Start)
//   Mode    - interpolation mode, selects segment length (1..10000 cycles)
//   Length  - waveform sample count, 0 means 4096; captured at playback start
//   Addr2   - current-sample read address
//   Addr1   - next-sample read address (wraps to 0 after Length-1)
//   Enable  - one-cycle pulse at each segment start
//   Wrap    - one-cycle pulse with Enable when the index returns to sample 0
//   Busy    - high while playing back
module interp_sequencer (
    input  logic        Fg_clk,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Stop,
    input  logic [2:0]  Mode,
    input  logic [11:0] Length,
    output logic [11:0] Addr2,
    output logic [11:0] Addr1,
    output logic        Enable,
    output logic        Wrap,
    output logic        Busy
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = 14;
    localparam int unsigned MODE_W = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr2_d, addr1_d;
    logic              enable_d, wrap_d, busy_d;
    logic [ADDR_W-1:0] idx_nxt;

    // Last counter value of a segment (segment length minus one) per mode.
    function automatic logic [CNT_W-1:0] seg_last(input logic [MODE_W-1:0] m);
        case (m)
            3'd1:    seg_last = CNT_W'(9);
            3'd2:    seg_last = CNT_W'(99);
            3'd3:    seg_last = CNT_W'(999);
            3'd4:    seg_last = CNT_W'(9999);
            default: seg_last = CNT_W'(0);
        endcase
    endfunction

    // Successor sample index; a stored length of 0 stands for 4096 samples.
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] i,
                                                   input logic [ADDR_W-1:0] len);
        logic [IDX_W-1:0] inc;
        logic [IDX_W-1:0] lim;
        inc = IDX_W'(i) + IDX_W'(1);
        lim = (len == '0) ? IDX_W'(4096) : IDX_W'(len);
        next_idx = (inc == lim) ? '0 : inc[ADDR_W-1:0];
    endfunction

    assign idx_nxt = next_idx(idx, len_q);

    // State and output registers.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            mode_q <= '0;
            len_q  <= '0;
            Addr2  <= '0;
            Addr1  <= '0;
            Enable <= 1'b0;
            Wrap   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            mode_q <= mode_d;
            len_q  <= len_d;
            Addr2  <= addr2_d;
            Addr1  <= addr1_d;
            Enable <= enable_d;
            Wrap   <= wrap_d;
            Busy   <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        mode_d   = mode_q;
        len_d    = len_q;
        addr2_d  = Addr2;
        addr1_d  = Addr1;
        enable_d = 1'b0;
        wrap_d   = 1'b0;
        busy_d   = Busy;

        case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (Start && !Stop) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    idx_d    = '0;
                    mode_d   = Mode;
                    len_d    = Length;
                    addr2_d  = '0;
                    addr1_d  = next_idx('0, Length);
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    addr2_d = '0;
                    addr1_d = '0;
                    busy_d  = 1'b0;
                end else if (cnt == seg_last(mode_q)) begin
                    // Segment boundary: step the index, resample Mode.
                    cnt_d    = '0;
                    idx_d    = idx_nxt;
                    mode_d   = Mode;
                    addr2_d  = idx_nxt;
                    addr1_d  = next_idx(idx_nxt, len_q);
                    enable_d = 1'b1;
                    wrap_d   = (idx_nxt == '0);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_interp_sequencer.sv
// Self-checking bench for interp_sequencer: expected Enable events are pushed
// to a queue from closed-form playback formulas, observed Enable events are
// collected each cycle, and each test compares the two queues.
module tb_interp_sequencer;

    typedef struct {
        int          cyc;
        logic [11:0] a2;
        logic [11:0] a1;
        logic        wr;
    } ev_t;

    logic        clk;
    logic        Resetn;
    logic        Start;
    logic        Stop;
    logic [2:0]  Mode;
    logic [11:0] Length;
    logic [11:0] Addr2;
    logic [11:0] Addr1;
    logic        Enable;
    logic        Wrap;
    logic        Busy;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int n_checks;
    int n_fail;
    int cyc;
    int stop_cyc;
    int chg_cyc;
    logic [2:0] chg_mode;
    int bad_wrap;
    int addr_glitch;
    logic [11:0] prev_a2;
    logic [11:0] prev_a1;

    interp_sequencer dut (
        .Fg_clk (clk),
        .Resetn (Resetn),
        .Start  (Start),
        .Stop   (Stop),
        .Mode   (Mode),
        .Length (Length),
        .Addr2  (Addr2),
        .Addr1  (Addr1),
        .Enable (Enable),
        .Wrap   (Wrap),
        .Busy   (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance n cycles; cycle 0 is the cycle Start is presented.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            Start = 1'b0;
            cyc++;
            Stop = (cyc == stop_cyc);
            if (cyc == chg_cyc) Mode = chg_mode;
            @(negedge clk);
            if (Enable) obs_q.push_back('{cyc, Addr2, Addr1, Wrap});
            if (Wrap && !Enable) bad_wrap++;
            if (Busy && !Enable && (Addr2 !== prev_a2 || Addr1 !== prev_a1)) addr_glitch++;
            prev_a2 = Addr2;
            prev_a1 = Addr1;
        end
    endtask

    task automatic go_idle();
        Stop = 1'b1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        Stop = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] m, input logic [11:0] l);
        Mode = m;
        Length = l;
        Start = 1'b1;
        Stop = 1'b0;
        cyc = 0;
        stop_cyc = -1;
        chg_cyc = -1;
        bad_wrap = 0;
        addr_glitch = 0;
        prev_a2 = Addr2;
        prev_a1 = Addr1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Start = 1'b0;
        Stop = 1'b0;
        Mode = 3'd0;
        Length = 12'd0;
        cyc = 0;
        stop_cyc = -1;
        chg_cyc = -1;
        #12;
        n_checks++;
        if ({Addr2, Addr1, Enable, Wrap, Busy} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a2=%0d a1=%0d en=%b wr=%b busy=%b, want all 0",
                     Addr2, Addr1, Enable, Wrap, Busy);
        end
        @(posedge clk);
        #1;
        Resetn = 1'b1;
        obs_q.delete();
        run_cycles(8);
        n_checks++;
        if (obs_q.size() != 0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %0d enables busy=%b, want 0 enables busy=0",
                     obs_q.size(), Busy);
        end
    endtask

    // Length=4, Mode=1: one segment every 10 cycles.
    task automatic test_mode1_len4();
        go_idle();
        start_run(3'd1, 12'd4);
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{1 + 10 * k, 12'(k % 4), 12'((k + 1) % 4), (k > 0 && k % 4 == 0)});
        run_cycles(45);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode1_len4_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL mode1_len4_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
        n_checks++;
        if (bad_wrap != 0 || addr_glitch != 0) begin
            n_fail++;
            $display("FAIL mode1_len4_stability: got wrap_without_en=%0d addr_changes=%0d, want 0 and 0",
                     bad_wrap, addr_glitch);
        end
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mode1_len4_busy: got %b, want 1", Busy);
        end
    endtask

    // Length=3, Mode=0: Enable every cycle, wrap every third.
    task automatic test_mode0_len3();
        go_idle();
        start_run(3'd0, 12'd3);
        for (int c = 1; c <= 10; c++)
            exp_q.push_back('{c, 12'((c - 1) % 3), 12'(c % 3), (c > 1 && (c - 1) % 3 == 0)});
        run_cycles(10);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode0_len3_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL mode0_len3_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
    endtask

    // Mode switches 1->2 mid-segment; new length applies from the next segment.
    task automatic test_mode_change();
        go_idle();
        start_run(3'd1, 12'd8);
        chg_cyc = 5;
        chg_mode = 3'd2;
        exp_q.push_back('{1, 12'd0, 12'd1, 1'b0});
        exp_q.push_back('{11, 12'd1, 12'd2, 1'b0});
        exp_q.push_back('{111, 12'd2, 12'd3, 1'b0});
        run_cycles(115);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode_change_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL mode_change_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
    endtask

    // Stop mid-run, then Start and Stop together from idle.
    task automatic test_stop();
        go_idle();
        start_run(3'd1, 12'd4);
        stop_cyc = 15;
        exp_q.push_back('{1, 12'd0, 12'd1, 1'b0});
        exp_q.push_back('{11, 12'd1, 12'd2, 1'b0});
        run_cycles(16);
        n_checks++;
        if (Busy !== 1'b0 || Addr2 !== 12'd0 || Addr1 !== 12'd0 || Enable !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_outputs: got busy=%b a2=%0d a1=%0d en=%b, want 0 0 0 0",
                     Busy, Addr2, Addr1, Enable);
        end
        run_cycles(20);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stop_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL stop_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
        start_run(3'd0, 12'd3);
        Stop = 1'b1;
        stop_cyc = -1;
        run_cycles(6);
        n_checks++;
        if (obs_q.size() != 0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle: got %0d enables busy=%b, want 0 enables busy=0",
                     obs_q.size(), Busy);
        end
    endtask

    // Length=1, Mode=7: index pinned at 0, Wrap every cycle after the first.
    task automatic test_len1_mode7();
        go_idle();
        start_run(3'd7, 12'd1);
        for (int c = 1; c <= 6; c++)
            exp_q.push_back('{c, 12'd0, 12'd0, (c >= 2)});
        run_cycles(6);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL len1_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL len1_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
    endtask

    // Length=0 means 4096 samples; Mode=5 gives one-cycle segments.
    task automatic test_len0_wrap();
        go_idle();
        start_run(3'd5, 12'd0);
        for (int c = 1; c <= 4098; c++)
            exp_q.push_back('{c, 12'((c - 1) % 4096), 12'(c % 4096), (c > 1 && (c - 1) % 4096 == 0)});
        run_cycles(4098);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL len0_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL len0_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
    endtask

    // Mode=4: 10000-cycle segments, Length=2.
    task automatic test_mode4_long();
        go_idle();
        start_run(3'd4, 12'd2);
        exp_q.push_back('{1, 12'd0, 12'd1, 1'b0});
        exp_q.push_back('{10001, 12'd1, 12'd0, 1'b0});
        run_cycles(10003);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode4_count: got %0d enables, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL mode4_ev%0d: got cyc=%0d a2=%0d a1=%0d wr=%b, want cyc=%0d a2=%0d a1=%0d wr=%b",
                         i, obs_q[i].cyc, obs_q[i].a2, obs_q[i].a1, obs_q[i].wr,
                         exp_q[i].cyc, exp_q[i].a2, exp_q[i].a1, exp_q[i].wr);
            end
        end
        n_checks++;
        if (addr_glitch != 0) begin
            n_fail++;
            $display("FAIL mode4_stability: got %0d address changes outside Enable, want 0", addr_glitch);
        end
    endtask

    // Asynchronous reset in the middle of a segment.
    task automatic test_reset_mid_run();
        go_idle();
        start_run(3'd1, 12'd4);
        run_cycles(17);
        #3;
        Resetn = 1'b0;
        #1;
        n_checks++;
        if ({Addr2, Addr1, Enable, Wrap, Busy} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got a2=%0d a1=%0d en=%b wr=%b busy=%b, want all 0",
                     Addr2, Addr1, Enable, Wrap, Busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        Resetn = 1'b1;
        obs_q.delete();
        run_cycles(20);
        n_checks++;
        if (obs_q.size() != 0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %0d enables busy=%b, want 0 enables busy=0",
                     obs_q.size(), Busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_mode1_len4();
        test_mode0_len3();
        test_mode_change();
        test_stop();
        test_len1_mode7();
        test_len0_wrap();
        test_mode4_long();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
